axil_csr_slave: RTL and testbench



---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_wr_ctrl.sv | 137 +++++++++++++
 rtl/axil_csr_slave.sv | 167 ++++++++++++++++
 tb/tb_axil_csr_slave.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and register map constants for the AXI4-Lite CSR slave.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    localparam int CTRL_IDX       = 0;
    localparam int STATUS_IDX     = 1;
    localparam int CTRL_START_BIT = 0;

endpackage

// File: rtl/axil_wr_ctrl.sv
// AXI4-Lite write channel: independent AW/W capture, commit strobe and B response.
// Byte strobes come from the bus only when AXIL_WSTRB_EN is defined.
module axil_wr_ctrl
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_LSB   = 2,
    localparam int IDX_W     = $clog2(NUM_REGS),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef AXIL_WSTRB_EN
    input  logic [STRB_W-1:0]     wstrb,
`endif
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    output logic                  commit_ok,
    output logic [IDX_W-1:0]      commit_idx,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [STRB_W-1:0]     commit_strb
);

    wr_state_t             state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    resp_t                 bresp_q, bresp_d;
    logic [31:0]           awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  aw_hs, w_hs, have_aw, have_w, commit, in_range;
    logic [31:0]           cur_addr;
    logic [STRB_W-1:0]     cur_strb;

    assign aw_hs    = awvalid && awready_q;
    assign w_hs     = wvalid && wready_q;
    assign have_aw  = aw_held_q || aw_hs;
    assign have_w   = w_held_q || w_hs;
    // A beat accepted this very edge is used directly so AW+W together commit immediately.
    assign cur_addr = aw_hs ? awaddr : awaddr_q;
    assign in_range = (cur_addr >> ADDR_LSB) < 32'(NUM_REGS);

`ifdef AXIL_WSTRB_EN
    assign cur_strb = w_hs ? wstrb : wstrb_q;
`else
    assign cur_strb = '1;
`endif

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (have_aw && have_w) begin
                    commit    = 1'b1;
                    state_d   = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = in_range ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    aw_held_d = have_aw;
                    w_held_d  = have_w;
                    awready_d = !have_aw;
                    wready_d  = !have_w;
                end
            end
            W_RESP: begin
                if (bready) begin
                    state_d   = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) awaddr_q <= awaddr;
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= cur_strb;
        end
    end

    assign awready     = awready_q;
    assign wready      = wready_q;
    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign commit_ok   = commit && in_range;
    assign commit_idx  = cur_addr[ADDR_LSB +: IDX_W];
    assign commit_data = w_hs ? wdata : wdata_q;
    assign commit_strb = cur_strb;

endmodule

// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR bank: CTRL with start pulse, live STATUS, RW config registers.
// Optional AXIL_WSTRB_EN adds a wstrb port for byte-lane writes.
module axil_csr_slave
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_LSB   = 2
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [31:0]                    awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
`ifdef AXIL_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
`endif
    input  logic                           wvalid,
    output logic                           wready,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic [31:0]                    araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_o,
    output logic                           start_o,
    input  logic [DATA_WIDTH-1:0]          sts_i
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  wc_ok;
    logic [IDX_W-1:0]      wc_idx;
    logic [DATA_WIDTH-1:0] wc_data;
    logic [STRB_W-1:0]     wc_strb;

    axil_wr_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .ADDR_LSB  (ADDR_LSB)
    ) u_wr_ctrl (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
`ifdef AXIL_WSTRB_EN
        .wstrb      (wstrb),
`endif
        .wvalid     (wvalid),
        .wready     (wready),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp),
        .commit_ok  (wc_ok),
        .commit_idx (wc_idx),
        .commit_data(wc_data),
        .commit_strb(wc_strb)
    );

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  start_q, start_d;

    always_comb begin
        wr_merged = regs_q[wc_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (wc_strb[b]) wr_merged[b*8 +: 8] = wc_data[b*8 +: 8];
        end
        // START is a pulse, never stored.
        if (wc_idx == IDX_W'(CTRL_IDX)) wr_merged[CTRL_START_BIT] = 1'b0;
        start_d = wc_ok && (wc_idx == IDX_W'(CTRL_IDX)) && wc_data[CTRL_START_BIT]
                  && wc_strb[CTRL_START_BIT/8];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= start_d;
            if (wc_ok && wc_idx != IDX_W'(STATUS_IDX)) regs_q[wc_idx] <= wr_merged;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) cfg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign start_o = start_q;

    rd_state_t             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_value;
    resp_t                 rresp_q, rresp_d;
    logic                  ar_hs, ar_ok;
    logic [IDX_W-1:0]      ar_idx;

    assign ar_hs  = arvalid && arready_q;
    assign ar_idx = araddr[ADDR_LSB +: IDX_W];
    assign ar_ok  = (araddr >> ADDR_LSB) < 32'(NUM_REGS);

    always_comb begin
        rd_value = '0;
        if (ar_ok) begin
            if (ar_idx == IDX_W'(STATUS_IDX)) rd_value = sts_i;
            else                              rd_value = regs_q[ar_idx];
        end

        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_value;
                    rresp_d    = ar_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rd_state_d = R_IDLE;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axil_csr_slave.sv
// Directed bench for axil_csr_slave with B/R response scoreboards.
module tb_axil_csr_slave;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  awaddr;
    logic         awvalid, awready;
    logic [31:0]  wdata;
`ifdef AXIL_WSTRB_EN
    logic [3:0]   wstrb;
`endif
    logic         wvalid, wready;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic [31:0]  araddr;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid, rready;
    logic [255:0] cfg_o;
    logic         start_o;
    logic [31:0]  sts_i;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];

    axil_csr_slave dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
`ifdef AXIL_WSTRB_EN
        .wstrb  (wstrb),
`endif
        .wvalid (wvalid),
        .wready (wready),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .cfg_o  (cfg_o),
        .start_o(start_o),
        .sts_i  (sts_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int i);
        return cfg_o[i*32 +: 32];
    endfunction

    // B monitor and start pulse counter
    always @(negedge aclk) begin
        if (start_o) start_cnt++;
        if (aresetn && bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
            else                check("bresp", {62'd0, bresp}, {62'd0, bq.pop_front()});
        end
    end

    // R monitor
    always @(negedge aclk) begin
        rexp_t e;
        if (aresetn && rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
            else begin
                e = rq.pop_front();
                check("rdata", {32'd0, rdata}, {32'd0, e.d});
                check("rresp", {62'd0, rresp}, {62'd0, e.r});
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] r, input logic st);
        int n = 0;
        logic aw_hs, w_hs;
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bq.push_back(r);
        while ((awvalid || wvalid) && n < 50) begin
            @(posedge aclk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            check("write_hs_timeout", 64'd1, 64'd0);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else begin
            check("b_latency", {63'd0, bvalid}, 64'd1);
            check("start_at_b", {63'd0, start_o}, {63'd0, st});
        end
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        int n = 0;
        logic ar_hs;
        araddr  = a;
        arvalid = 1'b1;
        rq.push_back({d, r});
        while (arvalid && n < 50) begin
            @(posedge aclk);
            ar_hs = arvalid && arready;
            #1;
            if (ar_hs) arvalid = 1'b0;
            n++;
        end
        if (arvalid) begin
            check("read_hs_timeout", 64'd1, 64'd0);
            arvalid = 1'b0;
        end else begin
            check("r_latency", {63'd0, rvalid}, 64'd1);
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (bq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (bq.size() != 0) check("b_timeout", 64'(bq.size()), 64'd0);
    endtask

    task automatic wait_r();
        int n = 0;
        while (rq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (rq.size() != 0) check("r_timeout", 64'(rq.size()), 64'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
`ifdef AXIL_WSTRB_EN
        wstrb   = 4'hF;
`endif
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        sts_i   = '0;

        // reset state
        repeat (3) tick();
        check("rst_readies", {61'd0, awready, wready, arready}, 64'd0);
        check("rst_valids", {61'd0, bvalid, rvalid, start_o}, 64'd0);
        check("rst_resp_data", {30'd0, bresp, rresp, rdata}, 64'd0);
        check("rst_cfg_zero", {63'd0, cfg_o == '0}, 64'd1);
        aresetn = 1'b1;
        tick();
        check("rdy_after_rst", {61'd0, awready, wready, arready}, 64'h7);

        // AW+W together, then read back
        write(32'h08, 32'hDEADBEEF, 2'b00, 1'b0);
        wait_b();
        check("slot2_write", {32'd0, slot(2)}, 64'hDEADBEEF);
        read(32'h08, 32'hDEADBEEF, 2'b00);
        wait_r();

        // W first, AW three cycles later
        wdata  = 32'h5;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wready_c1", {63'd0, wready}, 64'd0);
        check("no_b_c1", {63'd0, bvalid}, 64'd0);
        tick();
        check("wready_c2", {63'd0, wready}, 64'd0);
        tick();
        check("wready_c3", {63'd0, wready}, 64'd0);
        check("no_b_c3", {63'd0, bvalid}, 64'd0);
        awaddr  = 32'h0C;
        awvalid = 1'b1;
        bq.push_back(2'b00);
        tick();
        awvalid = 1'b0;
        check("b_c4", {63'd0, bvalid}, 64'd1);
        tick();
        check("b_single", {63'd0, bvalid}, 64'd0);
        check("slot3_write", {32'd0, slot(3)}, 64'h5);

        // CTRL start pulse
        start_cnt = 0;
        write(32'h00, 32'h3, 2'b00, 1'b1);
        wait_b();
        tick();
        check("start_pulses", 64'(start_cnt), 64'd1);
        read(32'h00, 32'h2, 2'b00);
        wait_r();
        write(32'h00, 32'h2, 2'b00, 1'b0);
        wait_b();
        write(32'h40, 32'h1, 2'b10, 1'b0);
        wait_b();
        tick();
        check("start_pulses_after", 64'(start_cnt), 64'd1);
        check("slot0_ctrl", {32'd0, slot(0)}, 64'h2);

        // B backpressure stalls the next write
        bready = 1'b0;
        write(32'h10, 32'h11, 2'b00, 1'b0);
        awaddr  = 32'h14;
        wdata   = 32'h22;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_b_rdy", {59'd0, bvalid, bresp, awready, wready}, 64'h10);
        end
        bq.push_back(2'b00);
        bready = 1'b1;
        tick();
        check("rdy_after_b", {61'd0, bvalid, awready, wready}, 64'h3);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("second_b", {63'd0, bvalid}, 64'd1);
        wait_b();
        check("slot4", {32'd0, slot(4)}, 64'h11);
        check("slot5", {32'd0, slot(5)}, 64'h22);

        // out of range, STATUS, unaligned, last register
        read(32'h40, 32'h0, 2'b10);
        wait_r();
        write(32'h40, 32'hFFFFFFFF, 2'b10, 1'b0);
        wait_b();
        check("oor_no_change", {32'd0, slot(0)}, 64'h2);
        write(32'h04, 32'h1234, 2'b00, 1'b0);
        wait_b();
        check("status_slot_zero", {32'd0, slot(1)}, 64'h0);
        sts_i = 32'hA5;
        read(32'h04, 32'hA5, 2'b00);
        wait_r();
        read(32'h0B, 32'hDEADBEEF, 2'b00);
        wait_r();
        write(32'h1C, 32'hCAFEF00D, 2'b00, 1'b0);
        wait_b();
        read(32'h1F, 32'hCAFEF00D, 2'b00);
        wait_r();

        // same-edge read and write to one register returns the old value
        araddr  = 32'h08;
        arvalid = 1'b1;
        awaddr  = 32'h08;
        wdata   = 32'h12345678;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        rq.push_back({32'hDEADBEEF, 2'b00});
        bq.push_back(2'b00);
        tick();
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("same_edge_valids", {62'd0, rvalid, bvalid}, 64'h3);
        wait_b();
        wait_r();
        check("slot2_new", {32'd0, slot(2)}, 64'h12345678);

        // reset while a read response is stalled
        rready  = 1'b0;
        araddr  = 32'h08;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rvalid_before_rst", {63'd0, rvalid}, 64'd1);
        tick();
        check("rvalid_held", {63'd0, rvalid}, 64'd1);
        aresetn = 1'b0;
        tick();
        check("rst_mid_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_mid_cfg", {63'd0, cfg_o == '0}, 64'd1);
        check("rst_mid_arready", {63'd0, arready}, 64'd0);
        aresetn = 1'b1;
        tick();
        check("arready_after_rel", {63'd0, arready}, 64'd1);
        rready = 1'b1;

`ifdef AXIL_WSTRB_EN
        wstrb = 4'b0010;
        write(32'h18, 32'hFFFFFFFF, 2'b00, 1'b0);
        wait_b();
        check("wstrb_lane1", {32'd0, slot(6)}, 64'h0000FF00);
        wstrb = 4'b1110;
        write(32'h00, 32'hFFFFFFFF, 2'b00, 1'b0);
        wait_b();
        check("wstrb_ctrl", {32'd0, slot(0)}, 64'hFFFFFF00);
        wstrb = 4'hF;
`endif

        repeat (3) tick();
        check("bq_drained", 64'(bq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
